branch_predictor: RTL

- Parametrised dynamic branch predictor: a direct-mapped branch target buffer (BTB) with one saturating direction counter per entry.
- Supplies a predicted next PC to IF in the same cycle as the fetch PC.
- Is trained from EX with the resolved outcome of each control instruction.
- Flags mispredictions for EX flush steering and keeps saturating branch and mispredict statistics for the debug path.

---
 rtl/branch_predictor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB with one saturating direction counter per
//                entry. Zero-latency lookup for IF, training and mispredict
//                detection from EX, and saturating branch/mispredict
//                statistics for the debug path.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 32,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_if,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_pc,
    input  logic            i_upd_vld,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_uncond,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_pred_taken,
    input  logic [XLEN-1:0] i_upd_pred_pc,
    output logic            o_mispred,
    output logic [31:0]     o_br_cnt,
    output logic [31:0]     o_mispred_cnt
);

    localparam logic [CTR_W-1:0] c_ctr_max    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctr_weak_t = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] c_ctr_rst    = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [XLEN-1:0]  c_pc_step    = XLEN'(4);
    localparam logic [31:0]      c_cnt_max    = 32'hFFFF_FFFF;

    // Table storage is flops so the lookup can be purely combinational
    logic                  r_valid  [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [XLEN-1:0]       r_target [ENTRIES];
    logic [CTR_W-1:0]      r_ctr    [ENTRIES];
    logic [31:0]           r_br_cnt;
    logic [31:0]           r_mispred_cnt;

    logic [IDX_W-1:0]      w_if_idx;
    logic [TAG_W-1:0]      w_if_tag;
    logic                  w_if_hit;
    logic [IDX_W-1:0]      w_upd_idx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic                  w_upd_hit;
    logic [XLEN-1:0]       w_upd_actual;
    logic [CTR_W-1:0]      w_ctr_next;
    logic                  w_alloc;
    logic                  w_unused;

    // Byte offset and the carried prediction bit carry no information here
    assign w_unused = ^{i_pc_if[1:0], i_upd_pc[1:0], i_upd_pred_taken};

    // Fetch-side lookup: returns the pre-update table contents (no bypass)
    assign w_if_idx     = i_pc_if[IDX_W+1:2];
    assign w_if_tag     = i_pc_if[XLEN-1:IDX_W+2];
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign o_pred_taken = w_if_hit && r_ctr[w_if_idx][CTR_W-1];
    assign o_pred_pc    = o_pred_taken ? r_target[w_if_idx] : (i_pc_if + c_pc_step);

    // Resolve-side: compare the carried next-PC against the real next-PC
    assign w_upd_idx    = i_upd_pc[IDX_W+1:2];
    assign w_upd_tag    = i_upd_pc[XLEN-1:IDX_W+2];
    assign w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_actual = i_upd_taken ? i_upd_target : (i_upd_pc + c_pc_step);
    assign o_mispred    = i_upd_vld && (i_upd_pred_pc != w_upd_actual);
    assign w_alloc      = !w_upd_hit && i_upd_taken;

    // Next direction counter value for the entry being trained
    always_comb begin
        w_ctr_next = r_ctr[w_upd_idx];
        if (!w_upd_hit) begin
            w_ctr_next = i_upd_uncond ? c_ctr_max : c_ctr_weak_t;
        end else if (i_upd_uncond) begin
            w_ctr_next = c_ctr_max;
        end else if (i_upd_taken) begin
            if (r_ctr[w_upd_idx] != c_ctr_max) begin
                w_ctr_next = r_ctr[w_upd_idx] + CTR_W'(1);
            end
        end else begin
            if (r_ctr[w_upd_idx] != '0) begin
                w_ctr_next = r_ctr[w_upd_idx] - CTR_W'(1);
            end
        end
    end

    // Valid bits and direction counters; reset wins over a concurrent update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= c_ctr_rst;
            end
        end else if (i_upd_vld && (w_upd_hit || w_alloc)) begin
            r_valid[w_upd_idx] <= 1'b1;
            r_ctr[w_upd_idx]   <= w_ctr_next;
        end
    end

    // Tags and targets need no reset: they are qualified by the valid bit
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_upd_vld) begin
            if (w_alloc) begin
                r_tag[w_upd_idx] <= w_upd_tag;
            end
            if (i_upd_taken) begin
                r_target[w_upd_idx] <= i_upd_target;
            end
        end
    end

    // Saturating statistics counters; they stick at all-ones instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (i_upd_vld) begin
            if (r_br_cnt != c_cnt_max) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (o_mispred && (r_mispred_cnt != c_cnt_max)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
